// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter: requester encoding and tracker entry.
// Purely declarative; no logic.
// No flow control here; users apply it.
package mem_port_arbiter_pkg;

   localparam logic ARB_OWN_IF  = 1'b0;
   localparam logic ARB_OWN_LSU = 1'b1;
   localparam int   ARB_TAG_WD  = 4;

   typedef struct packed {
      logic vld;
      logic own;
      logic store;
      logic killed;
   } arb_tag_t;

endpackage

// File: rtl/arb_inflight_pipe.sv
// In-flight read tracker: RD_LAT-deep shift register of grant tags, head aligns with SRAM data.
// Latency: head presents an entry exactly RD_LAT cycles after its push.
// No backpressure: shifts every cycle; kill marks IF entries (head included, combinationally).
module arb_inflight_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic push_own,
   input  logic push_store,
   input  logic kill,
   output logic head_vld,
   output logic head_own,
   output logic head_store,
   output logic head_killed,
   output logic lsu_pending
);

   logic [ARB_TAG_WD-1:0] stage_q [RD_LAT];
   arb_tag_t push_tag;
   arb_tag_t head;

   function automatic arb_tag_t apply_kill(input arb_tag_t t, input logic k);
      arb_tag_t r;
      r = t;
      if (k && t.vld && (t.own == ARB_OWN_IF))
         r.killed = 1'b1;
      return r;
   endfunction

   always_comb begin
      push_tag        = '0;
      push_tag.vld    = push;
      push_tag.own    = push_own;
      push_tag.store  = push_store;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++)
            stage_q[i] <= '0;
      end else begin
         stage_q[0] <= push_tag;
         for (int i = 1; i < RD_LAT; i++)
            stage_q[i] <= apply_kill(arb_tag_t'(stage_q[i-1]), kill);
      end
   end

   assign head        = apply_kill(arb_tag_t'(stage_q[RD_LAT-1]), kill);
   assign head_vld    = head.vld;
   assign head_own    = head.own;
   assign head_store  = head.store;
   assign head_killed = head.killed;

   // Entries still short of the head; the head itself completes this cycle.
   always_comb begin
      lsu_pending = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) begin
         if (stage_q[i][3] && (stage_q[i][2] == ARB_OWN_LSU))
            lsu_pending = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between IF (read) and LSU (read/write); LSU wins, optional anti-starvation via MEM_ARB_STARVE_GUARD_EN.
// Latency: grant same cycle as request; response exactly RD_LAT cycles after grant, fully pipelined.
// Backpressure: ungranted requests hold and raise stallreq_if / stallreq_mem.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT         = 1,
   parameter int MAX_LSU_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_e,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [7:0]  lsu_wstrb,
   input  logic [63:0] lsu_addr,
   input  logic [63:0] lsu_wdata,
   output logic        lsu_gnt,
   output logic        lsu_rvalid,
   output logic [63:0] lsu_rdata,
   output logic        sram_en,
   output logic [7:0]  sram_we,
   output logic [63:0] sram_addr,
   output logic [63:0] sram_wdata,
   input  logic [63:0] sram_rdata,
   output logic        stallreq_if,
   output logic        stallreq_mem
);

   logic rdy_q;
   logic force_if;
   logic head_vld, head_own, head_store, head_killed, lsu_pending;

   // Holds everything quiet for one cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdy_q <= 1'b0;
      else
         rdy_q <= 1'b1;
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] lsu_streak_q;

   assign force_if = (lsu_streak_q == 3'(MAX_LSU_STREAK)) & if_req & lsu_req & !br_e;

   // Saturates at the limit so a br_e cycle cannot wrap the counter past it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lsu_streak_q <= 3'd0;
      else if (!if_req || if_gnt)
         lsu_streak_q <= 3'd0;
      else if (lsu_gnt && (lsu_streak_q != 3'(MAX_LSU_STREAK)))
         lsu_streak_q <= lsu_streak_q + 3'd1;
   end
`else
   // Strict LSU priority; the streak limit has no effect in this build.
   assign force_if = (MAX_LSU_STREAK < 0);
`endif

   assign lsu_gnt = rdy_q & lsu_req & !force_if;
   assign if_gnt  = rdy_q & if_req & !lsu_gnt & !br_e;

   assign sram_en    = if_gnt | lsu_gnt;
   assign sram_we    = (lsu_gnt && lsu_we) ? lsu_wstrb : 8'h00;
   assign sram_addr  = lsu_gnt ? lsu_addr : (if_gnt ? if_addr : 64'd0);
   assign sram_wdata = (lsu_gnt && lsu_we) ? lsu_wdata : 64'd0;

   arb_inflight_pipe #(
      .RD_LAT (RD_LAT)
   ) u_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (sram_en),
      .push_own    (lsu_gnt ? ARB_OWN_LSU : ARB_OWN_IF),
      .push_store  (lsu_gnt & lsu_we),
      .kill        (br_e),
      .head_vld    (head_vld),
      .head_own    (head_own),
      .head_store  (head_store),
      .head_killed (head_killed),
      .lsu_pending (lsu_pending)
   );

   assign if_rvalid  = rdy_q & head_vld & (head_own == ARB_OWN_IF) & !head_killed;
   assign lsu_rvalid = rdy_q & head_vld & (head_own == ARB_OWN_LSU);
   assign if_rdata   = if_rvalid ? sram_rdata : 64'd0;
   assign lsu_rdata  = (lsu_rvalid && !head_store) ? sram_rdata : 64'd0;

   assign stallreq_if  = if_req & !if_gnt;
   assign stallreq_mem = (lsu_req & !lsu_gnt) | lsu_pending;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 (suffix _a) and RD_LAT=3 (suffix _b) share stimulus and an SRAM model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, br_e, if_req, lsu_req, lsu_we;
   logic [63:0] if_addr, lsu_addr, lsu_wdata;
   logic [7:0]  lsu_wstrb;

   logic        if_gnt_a, if_rvalid_a, lsu_gnt_a, lsu_rvalid_a, sram_en_a, stallreq_if_a, stallreq_mem_a;
   logic [63:0] if_rdata_a, lsu_rdata_a, sram_addr_a, sram_wdata_a, sram_rdata_a;
   logic [7:0]  sram_we_a;
   logic        if_gnt_b, if_rvalid_b, lsu_gnt_b, lsu_rvalid_b, sram_en_b, stallreq_if_b, stallreq_mem_b;
   logic [63:0] if_rdata_b, lsu_rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;
   logic [7:0]  sram_we_b;

   mem_port_arbiter #(.RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .br_e(br_e),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_wstrb(lsu_wstrb), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_gnt(lsu_gnt_a), .lsu_rvalid(lsu_rvalid_a), .lsu_rdata(lsu_rdata_a),
      .sram_en(sram_en_a), .sram_we(sram_we_a), .sram_addr(sram_addr_a), .sram_wdata(sram_wdata_a),
      .sram_rdata(sram_rdata_a), .stallreq_if(stallreq_if_a), .stallreq_mem(stallreq_mem_a));

   mem_port_arbiter #(.RD_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .br_e(br_e),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_wstrb(lsu_wstrb), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_gnt(lsu_gnt_b), .lsu_rvalid(lsu_rvalid_b), .lsu_rdata(lsu_rdata_b),
      .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b),
      .sram_rdata(sram_rdata_b), .stallreq_if(stallreq_if_b), .stallreq_mem(stallreq_mem_b));

   // SRAM model: one array, two read pipelines of depth 1 and 3.
   logic [63:0] mem [4096];
   logic [63:0] rd_a;
   logic [63:0] rd_b [3];
   logic [11:0] idx_a, idx_b;
   assign idx_a        = sram_addr_a[14:3];
   assign idx_b        = sram_addr_b[14:3];
   assign sram_rdata_a = rd_a;
   assign sram_rdata_b = rd_b[2];

   function automatic logic [63:0] init_word(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'h5EED_0000 + 32'(i * 3)};
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
   end

   always @(posedge clk) begin
      if (sram_en_a)
         for (int k = 0; k < 8; k++)
            if (sram_we_a[k]) mem[idx_a][k*8 +: 8] <= sram_wdata_a[k*8 +: 8];
      rd_a    <= mem[idx_a];
      rd_b[0] <= mem[idx_b];
      rd_b[1] <= rd_b[0];
      rd_b[2] <= rd_b[1];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [63:0] q_if_a[$], q_lsu_a[$], q_if_b[$], q_lsu_b[$];

   task automatic push_if(input logic [63:0] v);
      q_if_a.push_back(v);
      q_if_b.push_back(v);
   endtask

   task automatic push_lsu(input logic [63:0] v);
      q_lsu_a.push_back(v);
      q_lsu_b.push_back(v);
   endtask

   // Response monitors: every rvalid must match the next expected word.
   always @(negedge clk) begin
      if (if_rvalid_a) begin
         if (q_if_a.size() == 0) check("if_a_spurious", 64'(if_rvalid_a), 64'd0);
         else check("if_a_data", if_rdata_a, q_if_a.pop_front());
      end
      if (lsu_rvalid_a) begin
         if (q_lsu_a.size() == 0) check("lsu_a_spurious", 64'(lsu_rvalid_a), 64'd0);
         else check("lsu_a_data", lsu_rdata_a, q_lsu_a.pop_front());
      end
      if (if_rvalid_b) begin
         if (q_if_b.size() == 0) check("if_b_spurious", 64'(if_rvalid_b), 64'd0);
         else check("if_b_data", if_rdata_b, q_if_b.pop_front());
      end
      if (lsu_rvalid_b) begin
         if (q_lsu_b.size() == 0) check("lsu_b_spurious", 64'(lsu_rvalid_b), 64'd0);
         else check("lsu_b_data", lsu_rdata_b, q_lsu_b.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req    = 1'b0;
      lsu_req   = 1'b0;
      lsu_we    = 1'b0;
      lsu_wstrb = 8'h00;
      if_addr   = 64'd0;
      lsu_addr  = 64'd0;
      lsu_wdata = 64'd0;
   endtask

   logic [63:0] w;
   bit          exp_if;

   initial begin
      rst_n = 1'b0;
      br_e  = 1'b0;
      idle();
      if_req  = 1'b1;
      lsu_req = 1'b1;
      repeat (3) tick();
      check("rst_if_gnt", 64'(if_gnt_a), 64'd0);
      check("rst_lsu_gnt", 64'(lsu_gnt_a), 64'd0);
      check("rst_sram_en", 64'(sram_en_b), 64'd0);
      check("rst_lsu_rdata", lsu_rdata_b, 64'd0);
      idle();
      rst_n = 1'b1;
      tick();

      // IF-only back-to-back reads
      tick(); if_req = 1'b1; if_addr = 64'h8000_0000; #1;
      check("t1_gnt0", 64'(if_gnt_a), 64'd1);
      check("t1_sram_addr", sram_addr_a, 64'h8000_0000);
      check("t1_sram_we", 64'(sram_we_a), 64'd0);
      push_if(init_word(0));
      tick(); if_addr = 64'h8000_0008; #1;
      check("t1_gnt1", 64'(if_gnt_a), 64'd1);
      check("t1_rv0", 64'(if_rvalid_a), 64'd1);
      push_if(init_word(1));
      tick(); idle(); #1;
      check("t1_rv1", 64'(if_rvalid_a), 64'd1);

      // Simultaneous IF and LSU load: LSU first
      tick(); if_req = 1'b1; if_addr = 64'h8000_0010; lsu_req = 1'b1; lsu_addr = 64'h1000; #1;
      check("t2_lsu_gnt", 64'(lsu_gnt_a), 64'd1);
      check("t2_if_gnt", 64'(if_gnt_a), 64'd0);
      check("t2_stall_if", 64'(stallreq_if_a), 64'd1);
      check("t2_sram_addr", sram_addr_a, 64'h1000);
      push_lsu(init_word(12'h200));
      tick(); lsu_req = 1'b0; #1;
      check("t2_if_gnt_next", 64'(if_gnt_a), 64'd1);
      check("t2_lsu_rv", 64'(lsu_rvalid_a), 64'd1);
      check("t2_if_rv_early", 64'(if_rvalid_a), 64'd0);
      check("t2_stall_mem_b", 64'(stallreq_mem_b), 64'd1);
      push_if(init_word(2));
      tick(); idle(); #1;
      check("t2_if_rv", 64'(if_rvalid_a), 64'd1);
      check("t2_lsu_rv_done", 64'(lsu_rvalid_a), 64'd0);

      // Partial store then load back
      tick(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_wstrb = 8'h0F; lsu_addr = 64'h2000; lsu_wdata = 64'h1122_3344; #1;
      check("t3_lsu_gnt", 64'(lsu_gnt_a), 64'd1);
      check("t3_sram_we", 64'(sram_we_a), 64'h0F);
      check("t3_sram_wdata", sram_wdata_a, 64'h1122_3344);
      push_lsu(64'd0);
      tick(); lsu_we = 1'b0; lsu_wstrb = 8'h00; #1;
      check("t3_store_ack", 64'(lsu_rvalid_a), 64'd1);
      check("t3_store_rdata", lsu_rdata_a, 64'd0);
      w = init_word(12'h400);
      push_lsu({w[63:32], 32'h1122_3344});
      tick(); idle();
      repeat (4) tick();

      // Branch flush kills an in-flight IF read; LSU load unaffected
      tick(); if_req = 1'b1; if_addr = 64'h8000_0018; #1;
      check("t4_if_gnt", 64'(if_gnt_a), 64'd1);
      tick(); if_req = 1'b0; br_e = 1'b1; lsu_req = 1'b1; lsu_addr = 64'h1008; #1;
      check("t4_lsu_gnt", 64'(lsu_gnt_a), 64'd1);
      check("t4_kill_head_a", 64'(if_rvalid_a), 64'd0);
      push_lsu(init_word(12'h201));
      tick(); lsu_req = 1'b0; if_req = 1'b1; #1;
      check("t4_br_no_gnt", 64'(if_gnt_a), 64'd0);
      check("t4_br_no_en", 64'(sram_en_a), 64'd0);
      check("t4_br_stall_if", 64'(stallreq_if_a), 64'd1);
      check("t4_lsu_rv_a", 64'(lsu_rvalid_a), 64'd1);
      tick(); idle(); br_e = 1'b0; #1;
      check("t4_kill_b", 64'(if_rvalid_b), 64'd0);
      check("t4_lsu_b_early", 64'(lsu_rvalid_b), 64'd0);
      tick();
      check("t4_lsu_b_lat3", 64'(lsu_rvalid_b), 64'd1);
      repeat (3) tick();

      // Both requesters held high
      for (int i = 0; i < 10; i++) begin
         tick();
         if_req = 1'b1; if_addr = 64'h8000_0020;
         lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h1010;
         #1;
         exp_if = GUARD && ((i % 5) == 4);
         check("t5_if_gnt", 64'(if_gnt_a), 64'(exp_if));
         check("t5_lsu_gnt", 64'(lsu_gnt_a), 64'(!exp_if));
         if (exp_if) push_if(init_word(4));
         else        push_lsu(init_word(12'h202));
      end
      tick(); idle();
      repeat (4) tick();

      // Reset with entries in flight
      tick(); if_req = 1'b1; if_addr = 64'h8000_0000; #1;
      check("t6_if_gnt", 64'(if_gnt_a), 64'd1);
      q_if_a.push_back(init_word(0));
      tick(); if_req = 1'b0; lsu_req = 1'b1; lsu_addr = 64'h1000; #1;
      check("t6_lsu_gnt", 64'(lsu_gnt_a), 64'd1);
      tick(); idle(); rst_n = 1'b0; #1;
      check("t6_rst_lsu_rv_a", 64'(lsu_rvalid_a), 64'd0);
      check("t6_rst_lsu_rdata_a", lsu_rdata_a, 64'd0);
      check("t6_rst_lsu_rv_b", 64'(lsu_rvalid_b), 64'd0);
      repeat (2) tick();
      tick(); rst_n = 1'b1; if_req = 1'b1; if_addr = 64'h8000_0008; #1;
      check("t6_rdy_gate", 64'(if_gnt_a), 64'd0);
      tick();
      check("t6_first_gnt", 64'(if_gnt_a), 64'd1);
      push_if(init_word(1));
      tick(); idle();
      repeat (5) tick();

      check("q_if_a_empty", 64'(q_if_a.size()), 64'd0);
      check("q_lsu_a_empty", 64'(q_lsu_a.size()), 64'd0);
      check("q_if_b_empty", 64'(q_if_b.size()), 64'd0);
      check("q_lsu_b_empty", 64'(q_lsu_b.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
